// File: rtl/lfsr_fpu_pkg.sv
// Shared constants, state encoding and next-state function of the 8-bit XNOR
// allocation LFSR that the checker follows.
package lfsr_fpu_pkg;

  localparam int LFSR_W = 8;
  localparam int TAP_HI = 7;
  localparam int TAP_LO = 3;
  localparam logic [LFSR_W-1:0] LOCKUP_STATE = 8'hFF;

  typedef enum logic {
    SYNC   = 1'b0,
    LOCKED = 1'b1
  } lfsr_chk_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ~(s[TAP_HI] ^ s[TAP_LO])};
  endfunction

endpackage

// File: rtl/lfsr_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module lfsr_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/lfsr_fpu_checker.sv
// Receive-side checker: rebuilds the allocator LFSR state from the observed
// index stream, then predicts and checks every following index.
//
// state  | meaning
// SYNC   | shifting sample bit 0 into ref until 8 consistent samples are seen
// LOCKED | comparing each sample with next(ref), dropping back after LOSS_THRESH misses
module lfsr_fpu_checker
  import lfsr_fpu_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int LOSS_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  valid_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  locked_o,
  output logic                  error_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  output logic [CNT_WIDTH-1:0]  chk_cnt_o,
  output logic                  lockup_o
);

  if ((ADDR_WIDTH < 1) || (ADDR_WIDTH > LFSR_W)) begin : g_bad_addr_width
    $error("lfsr_fpu_checker: ADDR_WIDTH must be in 1..8");
  end
  if ((LOSS_THRESH < 1) || (LOSS_THRESH > 255)) begin : g_bad_loss_thresh
    $error("lfsr_fpu_checker: LOSS_THRESH must be in 1..255");
  end

  localparam logic [7:0] LOSS_TH = 8'(LOSS_THRESH);

  lfsr_chk_state_e   state_q, state_d;
  logic [LFSR_W-1:0] ref_q, ref_d, ref_nxt;
  logic [3:0]        sync_cnt_q, sync_cnt_d;
  logic [7:0]        miss_q, miss_d;
  logic              err_q, err_d;
  logic              lockup_q, lockup_d;
  logic              sync_ok, chk_inc, err_inc;

  assign ref_nxt = lfsr_next(ref_q);

  // Consecutive samples overlap by ADDR_WIDTH-1 bits; a 1-bit stream has nothing to cross-check.
  if (ADDR_WIDTH > 1) begin : g_prev
    logic [ADDR_WIDTH-1:0] prev_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prev_q <= '0;
      end else if (clear_i) begin
        prev_q <= '0;
      end else if (valid_i) begin
        prev_q <= addr_i;
      end
    end
    assign sync_ok = (addr_i[ADDR_WIDTH-1:1] == prev_q[ADDR_WIDTH-2:0]);
  end else begin : g_no_prev
    assign sync_ok = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    ref_d      = ref_q;
    sync_cnt_d = sync_cnt_q;
    miss_d     = miss_q;
    err_d      = 1'b0;
    lockup_d   = lockup_q;
    chk_inc    = 1'b0;
    err_inc    = 1'b0;
    if (clear_i) begin
      state_d    = SYNC;
      ref_d      = '0;
      sync_cnt_d = '0;
      miss_d     = '0;
      lockup_d   = 1'b0;
    end else if (valid_i) begin
      case (state_q)
        SYNC: begin
          ref_d = {ref_q[LFSR_W-2:0], addr_i[0]};
          if ((sync_cnt_q != 4'd0) && !sync_ok) begin
            sync_cnt_d = 4'd1;
          end else if (sync_cnt_q == 4'd7) begin
            state_d    = LOCKED;
            sync_cnt_d = '0;
          end else begin
            sync_cnt_d = sync_cnt_q + 4'd1;
          end
        end
        default: begin
          ref_d   = ref_nxt;
          chk_inc = 1'b1;
          if (addr_i != ref_nxt[ADDR_WIDTH-1:0]) begin
            err_d   = 1'b1;
            err_inc = 1'b1;
            if ((miss_q + 8'd1) == LOSS_TH) begin
              state_d    = SYNC;
              sync_cnt_d = '0;
              miss_d     = '0;
            end else begin
              miss_d = miss_q + 8'd1;
            end
          end else begin
            miss_d = '0;
          end
        end
      endcase
      if (ref_d == LOCKUP_STATE) begin
        lockup_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SYNC;
      ref_q      <= '0;
      sync_cnt_q <= '0;
      miss_q     <= '0;
      err_q      <= 1'b0;
      lockup_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ref_q      <= ref_d;
      sync_cnt_q <= sync_cnt_d;
      miss_q     <= miss_d;
      err_q      <= err_d;
      lockup_q   <= lockup_d;
    end
  end

  lfsr_sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (err_inc),
    .clr_i (clear_i),
    .cnt_o (err_cnt_o)
  );

  lfsr_sat_counter #(.WIDTH(CNT_WIDTH)) u_chk_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (chk_inc),
    .clr_i (clear_i),
    .cnt_o (chk_cnt_o)
  );

  assign locked_o = (state_q == LOCKED);
  assign error_o  = err_q;
  assign lockup_o = lockup_q;

endmodule

// File: tb/tb_lfsr_fpu_checker.sv
// Scoreboard bench for lfsr_fpu_checker: each driven sample pushes the
// expected post-edge outputs, which are popped and compared after the edge.
module tb_lfsr_fpu_checker;

  localparam int AW  = 4;
  localparam int CW  = 16;
  localparam int LTH = 4;

  logic          clk;
  logic          rst_n;
  logic          clear_i;
  logic          valid_i;
  logic [AW-1:0] addr_i;
  logic          locked_o;
  logic          error_o;
  logic [CW-1:0] err_cnt_o;
  logic [CW-1:0] chk_cnt_o;
  logic          lockup_o;

  lfsr_fpu_checker #(
    .ADDR_WIDTH  (AW),
    .CNT_WIDTH   (CW),
    .LOSS_THRESH (LTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (clear_i),
    .valid_i   (valid_i),
    .addr_i    (addr_i),
    .locked_o  (locked_o),
    .error_o   (error_o),
    .err_cnt_o (err_cnt_o),
    .chk_cnt_o (chk_cnt_o),
    .lockup_o  (lockup_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic err;
    logic lock;
    int   errc;
    int   chkc;
    int   lku;   // 2 = not checked on this sample
  } exp_t;

  exp_t sb_q[$];
  int   n_checks   = 0;
  int   n_failures = 0;

  // bench-side expectation state
  logic       e_locked;
  int         e_errc;
  int         e_chkc;
  int         e_lockup;
  logic [7:0] st;

  function automatic logic [7:0] gen_next(input logic [7:0] s);
    return {s[6:0], ~(s[7] ^ s[3])};
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_failures++;
      $display("FAIL scoreboard_empty got=0 exp=1");
    end else begin
      e = sb_q.pop_front();
      chk_eq("error_o",   32'(error_o),   32'(e.err));
      chk_eq("locked_o",  32'(locked_o),  32'(e.lock));
      chk_eq("err_cnt_o", 32'(err_cnt_o), e.errc);
      chk_eq("chk_cnt_o", 32'(chk_cnt_o), e.chkc);
      if (e.lku != 2) chk_eq("lockup_o", 32'(lockup_o), e.lku);
    end
  endtask

  task automatic step(input logic v, input logic [AW-1:0] a, input logic clr,
                      input logic exp_err, input logic exp_lock);
    exp_t e;
    @(negedge clk);
    valid_i = v;
    addr_i  = a;
    clear_i = clr;
    if (clr) begin
      e_errc   = 0;
      e_chkc   = 0;
      e_lockup = 0;
    end else if (v) begin
      if (e_locked) e_chkc++;
      if (exp_err) e_errc++;
    end
    e_locked = exp_lock;
    e.err  = exp_err;
    e.lock = exp_lock;
    e.errc = e_errc;
    e.chkc = e_chkc;
    e.lku  = e_lockup;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  task automatic feed_sync();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, st[AW-1:0], 1'b0, 1'b0, i == 7);
      st = gen_next(st);
    end
  endtask

  task automatic feed_good(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, st[AW-1:0], 1'b0, 1'b0, 1'b1);
      st = gen_next(st);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'hA, 1'b0, 1'b0, e_locked);
  endtask

  task automatic check_all_zero(input string tag);
    chk_eq({tag, "_locked"}, 32'(locked_o),  0);
    chk_eq({tag, "_error"},  32'(error_o),   0);
    chk_eq({tag, "_errcnt"}, 32'(err_cnt_o), 0);
    chk_eq({tag, "_chkcnt"}, 32'(chk_cnt_o), 0);
    chk_eq({tag, "_lockup"}, 32'(lockup_o),  0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    clear_i  = 1'b0;
    valid_i  = 1'b0;
    addr_i   = '0;
    e_locked = 1'b0;
    e_errc   = 0;
    e_chkc   = 0;
    e_lockup = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // seed-0 stream: 0,1,3,7,F,E,C,8 then 0,0,0,0,0,1 with no errors
    st = 8'h00;
    feed_sync();
    feed_good(6);

    // expected 3, drive 2: one isolated error, lock held, then recover on 7
    step(1'b1, st[AW-1:0] ^ 4'h1, 1'b0, 1'b1, 1'b1);
    st = gen_next(st);
    feed_good(1);

    // LOSS_THRESH consecutive misses drop lock on the last one
    for (int i = 0; i < LTH; i++) begin
      step(1'b1, ~st[AW-1:0], 1'b0, 1'b1, i < LTH - 1);
      st = gen_next(st);
    end
    feed_sync();

    // idle gap mid-stream changes nothing
    idle(3);
    feed_good(3);

    // clear with a valid sample present: sample dropped, everything zeroed
    step(1'b1, 4'hF, 1'b1, 1'b0, 1'b0);

    // 1 then 5 breaks sync; 5 starts a fresh run of 8
    step(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    st = 8'h05;
    feed_sync();
    feed_good(2);

    // stuck generator: all-ones reference sets sticky lockup
    step(1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      e_lockup = (i < 7) ? 0 : ((i == 7) ? 2 : 1);
      step(1'b1, 4'hF, 1'b0, 1'b0, i >= 7);
    end
    idle(2);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);

    // async reset mid-LOCKED while valid_i is high
    st = 8'h5A;
    feed_sync();
    feed_good(2);
    @(negedge clk);
    valid_i = 1'b1;
    addr_i  = st[AW-1:0];
    rst_n   = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst_n    = 1'b1;
    e_locked = 1'b0;
    e_errc   = 0;
    e_chkc   = 0;
    e_lockup = 0;
    feed_sync();
    feed_good(2);

    @(negedge clk);
    valid_i = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
